// File: rtl/register_file_pkg.sv
// Shared constants, address-width helper and word typedefs for register_file_mp.
package register_file_pkg;

  localparam int RF_NUM_REGS_DEF = 16;
  localparam int RF_DATA_W_DEF   = 64;
  localparam int RF_NUM_RD_DEF   = 2;
  localparam int RF_NUM_WR_DEF   = 2;

  // Never narrower than one bit, so a two-entry file still has an address.
  function automatic int rf_addr_w(input int num_regs);
    return (num_regs > 2) ? $clog2(num_regs) : 1;
  endfunction

  typedef logic [rf_addr_w(RF_NUM_REGS_DEF)-1:0] rf_addr_t;
  typedef logic [RF_DATA_W_DEF-1:0]              rf_data_t;

endpackage

// File: rtl/register_file_mp_rf_read_port.sv
// One registered read port: address decode, optional same-edge write bypass
// (RF_BYPASS_EN) and the rd_data / rd_valid / rd_pending output flops.
module rf_read_port #(
  parameter int NUM_REGS = 16,
  parameter int DATA_W   = 64,
  parameter int AW       = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  input  logic [DATA_W-1:0] regs [NUM_REGS],
  input  logic [NUM_REGS-1:0] pending,
`ifdef RF_BYPASS_EN
  input  logic [DATA_W-1:0] regs_nxt [NUM_REGS],
  input  logic [NUM_REGS-1:0] wr_hit,
  input  logic [NUM_REGS-1:0] rsv_hit,
`endif
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_pending
);

  logic [DATA_W-1:0] sel_data;
  logic              sel_pend;

  // Addresses at or beyond NUM_REGS match no entry and therefore read as 0, pending 0.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; otherwise a latch is inferred.
    sel_data = '0;
    sel_pend = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (rd_addr == AW'(r)) begin
        sel_data = regs[r];
        sel_pend = pending[r];
`ifdef RF_BYPASS_EN
        if (wr_hit[r]) begin
          sel_data = regs_nxt[r];
          sel_pend = rsv_hit[r];
        end
`endif
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      rd_pending <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data    <= sel_data;
        rd_pending <= sel_pend;
      end
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-ported register file with write-priority resolution and pending scoreboard.
// Define RF_BYPASS_EN to forward same-edge write data to reads of that register.
module register_file_mp
  import register_file_pkg::*;
#(
  parameter int NUM_REGS = RF_NUM_REGS_DEF,
  parameter int DATA_W   = RF_DATA_W_DEF,
  parameter int NUM_RD   = RF_NUM_RD_DEF,
  parameter int NUM_WR   = RF_NUM_WR_DEF,
  localparam int AW      = rf_addr_w(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  output logic [NUM_RD-1:0]        rd_pending,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*AW-1:0]     wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     rsv_en,
  input  logic [AW-1:0]            rsv_addr,
  output logic [NUM_REGS-1:0]      pending_vec
);

  logic [DATA_W-1:0]   regs     [NUM_REGS];
  logic [DATA_W-1:0]   regs_nxt [NUM_REGS];
  logic [NUM_REGS-1:0] wr_hit;
  logic [NUM_REGS-1:0] rsv_hit;
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_nxt;

  // Ports scanned in ascending order so the highest-index writer of a register wins.
  // A reserve is OR-ed in after the write clear, so reserve beats write on the same register.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      regs_nxt[r] = regs[r];
      wr_hit[r]   = 1'b0;
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && (wr_addr[w*AW +: AW] == AW'(r))) begin
          regs_nxt[r] = wr_data[w*DATA_W +: DATA_W];
          wr_hit[r]   = 1'b1;
        end
      end
      rsv_hit[r]     = rsv_en && (rsv_addr == AW'(r));
      pending_nxt[r] = rsv_hit[r] | (pending[r] & ~wr_hit[r]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the storage array is reset explicitly because every register must read 0 after reset;
      // this keeps it in flops rather than a RAM macro.
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
      pending <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= regs_nxt[r];
      pending <= pending_nxt;
    end
  end

  assign pending_vec = pending;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    rf_read_port #(
      .NUM_REGS(NUM_REGS),
      .DATA_W  (DATA_W),
      .AW      (AW)
    ) u_rd (
      .clk       (clk),
      .reset     (reset),
      .rd_en     (rd_en[i]),
      .rd_addr   (rd_addr[i*AW +: AW]),
      .regs      (regs),
      .pending   (pending),
`ifdef RF_BYPASS_EN
      .regs_nxt  (regs_nxt),
      .wr_hit    (wr_hit),
      .rsv_hit   (rsv_hit),
`endif
      .rd_data   (rd_data[i*DATA_W +: DATA_W]),
      .rd_valid  (rd_valid[i]),
      .rd_pending(rd_pending[i])
    );
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Scoreboard bench for register_file_mp at default parameters; expectations track RF_BYPASS_EN.
module tb_register_file_mp;
  import register_file_pkg::*;

  localparam int NR  = 16;
  localparam int DW  = 64;
  localparam int NRD = 2;
  localparam int NWR = 2;
  localparam int AW  = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic [NRD-1:0]     rd_en;
  logic [NRD*AW-1:0]  rd_addr;
  logic [NRD*DW-1:0]  rd_data;
  logic [NRD-1:0]     rd_valid;
  logic [NRD-1:0]     rd_pending;
  logic [NWR-1:0]     wr_en;
  logic [NWR*AW-1:0]  wr_addr;
  logic [NWR*DW-1:0]  wr_data;
  logic               rsv_en;
  logic [AW-1:0]      rsv_addr;
  logic [NR-1:0]      pending_vec;

  typedef struct {
    int       port;
    rf_data_t data;
    logic     pend;
  } exp_t;

  exp_t          sb [$];
  rf_data_t      m_regs [NR];
  logic [NR-1:0] m_pend;
  int            n_tests = 0;
  int            n_fail  = 0;

  register_file_mp dut (
    .clk        (clk),
    .reset      (reset),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_pending (rd_pending),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rsv_en     (rsv_en),
    .rsv_addr   (rsv_addr),
    .pending_vec(pending_vec)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    rd_en = '0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0;
  endtask

  task automatic model_reset();
    for (int r = 0; r < NR; r++) m_regs[r] = '0;
    m_pend = '0;
  endtask

  task automatic drive_wr(input int p, input int a, input rf_data_t d);
    wr_en[p] = 1'b1;
    wr_addr[p*AW +: AW] = AW'(a);
    wr_data[p*DW +: DW] = d;
  endtask

  task automatic drive_rd(input int p, input int a);
    rd_en[p] = 1'b1;
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic drive_rsv(input int a);
    rsv_en = 1'b1;
    rsv_addr = AW'(a);
  endtask

  // Push expected reads from the model, advance one edge, then drain the scoreboard.
  task automatic step();
    rf_data_t       d;
    logic           pd;
    int             a;
    logic [NRD-1:0] en_s;
    exp_t           e;
    en_s = rd_en;
    for (int p = 0; p < NRD; p++) begin
      if (rd_en[p]) begin
        a  = int'(rd_addr[p*AW +: AW]);
        d  = m_regs[a];
        pd = m_pend[a];
`ifdef RF_BYPASS_EN
        for (int w = 0; w < NWR; w++) begin
          if (wr_en[w] && int'(wr_addr[w*AW +: AW]) == a) begin
            d  = wr_data[w*DW +: DW];
            pd = rsv_en && (int'(rsv_addr) == a);
          end
        end
`endif
        sb.push_back('{port: p, data: d, pend: pd});
      end
    end
    for (int w = 0; w < NWR; w++) begin
      if (wr_en[w]) begin
        a = int'(wr_addr[w*AW +: AW]);
        m_regs[a] = wr_data[w*DW +: DW];
        m_pend[a] = 1'b0;
      end
    end
    if (rsv_en) m_pend[int'(rsv_addr)] = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (rd_valid !== en_s) begin
      n_fail++;
      $display("FAIL rd_valid: got %b expected %b", rd_valid, en_s);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_tests++;
      if (rd_data[e.port*DW +: DW] !== e.data || rd_pending[e.port] !== e.pend) begin
        n_fail++;
        $display("FAIL read_port%0d: got data %h pend %b expected data %h pend %b",
                 e.port, rd_data[e.port*DW +: DW], rd_pending[e.port], e.data, e.pend);
      end
    end
    n_tests++;
    if (pending_vec !== m_pend) begin
      n_fail++;
      $display("FAIL pending_vec: got %h expected %h", pending_vec, m_pend);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    model_reset();
    rd_en = 2'b11;
    repeat (3) begin
      @(posedge clk);
      #1;
      n_tests++;
      if (rd_valid !== 2'b00 || pending_vec !== 16'h0 || rd_data !== '0) begin
        n_fail++;
        $display("FAIL reset_hold: got valid %b pend %h data %h expected all zero",
                 rd_valid, pending_vec, rd_data);
      end
    end
    reset = 1'b0;
    for (int r = 0; r < NR; r += 2) begin
      clear_inputs();
      drive_rd(0, r);
      drive_rd(1, r + 1);
      step();
    end
  endtask

  task automatic test_write_read();
    clear_inputs();
    drive_wr(0, 5, 64'hDEAD_BEEF_0000_0005);
    step();
    clear_inputs();
    drive_rd(0, 5);
    drive_rd(1, 5);
    step();
    n_tests++;
    if (rd_valid !== 2'b11 || rd_data !== {2{64'hDEAD_BEEF_0000_0005}}) begin
      n_fail++;
      $display("FAIL write_read: got valid %b data %h expected 11 and r5 on both", rd_valid, rd_data);
    end
  endtask

  task automatic test_collision();
    clear_inputs();
    drive_wr(0, 3, 64'h1);
    drive_wr(1, 3, 64'h2);
    step();
    clear_inputs();
    drive_wr(0, 0, 64'h0123_4567_89AB_CDEF);
    drive_wr(1, 15, 64'hFEDC_BA98_7654_3210);
    drive_rd(1, 3);
    step();
    n_tests++;
    if (rd_data[DW +: DW] !== 64'h2) begin
      n_fail++;
      $display("FAIL collision: got %h expected %h", rd_data[DW +: DW], 64'h2);
    end
    clear_inputs();
    drive_rd(0, 0);
    drive_rd(1, 15);
    step();
  endtask

  task automatic test_hold();
    clear_inputs();
    drive_rd(0, 5);
    step();
    clear_inputs();
    drive_rd(0, 3);
    rd_en = 2'b00;
    step();
    n_tests++;
    if (rd_data[0 +: DW] !== 64'hDEAD_BEEF_0000_0005 || rd_pending[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL hold: got data %h pend %b expected %h pend 0",
               rd_data[0 +: DW], rd_pending[0], 64'hDEAD_BEEF_0000_0005);
    end
  endtask

  task automatic test_scoreboard();
    clear_inputs();
    drive_rsv(7);
    drive_rd(0, 7);
    step();
    n_tests++;
    if (pending_vec[7] !== 1'b1 || rd_pending[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reserve_r7: got pending_vec %h rd_pending %b expected bit7=1 and 0",
               pending_vec, rd_pending[0]);
    end
    clear_inputs();
    drive_rd(1, 7);
    step();
    n_tests++;
    if (rd_pending[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL read_pending_r7: got %b expected 1", rd_pending[1]);
    end
    clear_inputs();
    drive_wr(1, 7, 64'h77);
    step();
    n_tests++;
    if (pending_vec[7] !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_r7: got %b expected 0", pending_vec[7]);
    end
    clear_inputs();
    drive_rsv(9);
    drive_wr(0, 9, 64'h99);
    step();
    n_tests++;
    if (pending_vec[9] !== 1'b1) begin
      n_fail++;
      $display("FAIL rsv_wins_r9: got %b expected 1", pending_vec[9]);
    end
  endtask

  task automatic test_bypass();
    rf_data_t exp_d;
    logic     exp_p;
    clear_inputs();
    drive_wr(0, 2, 64'hA);
    step();
    clear_inputs();
    drive_wr(0, 2, 64'hC);
    drive_wr(1, 2, 64'hB);
    drive_rd(0, 2);
    step();
`ifdef RF_BYPASS_EN
    exp_d = 64'hB;
`else
    exp_d = 64'hA;
`endif
    n_tests++;
    if (rd_data[0 +: DW] !== exp_d) begin
      n_fail++;
      $display("FAIL bypass_data: got %h expected %h", rd_data[0 +: DW], exp_d);
    end
    clear_inputs();
    drive_wr(0, 2, 64'hD);
    drive_rsv(2);
    drive_rd(1, 2);
    step();
`ifdef RF_BYPASS_EN
    exp_p = 1'b1;
`else
    exp_p = 1'b0;
`endif
    n_tests++;
    if (rd_pending[1] !== exp_p) begin
      n_fail++;
      $display("FAIL bypass_rsv: got %b expected %b", rd_pending[1], exp_p);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      clear_inputs();
      for (int p = 0; p < NRD; p++) begin
        if ($urandom_range(0, 3) != 0) drive_rd(p, int'($urandom_range(0, NR - 1)));
      end
      for (int w = 0; w < NWR; w++) begin
        if ($urandom_range(0, 2) == 0)
          drive_wr(w, int'($urandom_range(0, NR - 1)), {$urandom, $urandom});
      end
      if ($urandom_range(0, 2) == 0) drive_rsv(int'($urandom_range(0, NR - 1)));
      step();
    end
  endtask

  task automatic test_reset_midop();
    clear_inputs();
    drive_wr(0, 4, 64'hFF);
    drive_rsv(4);
    step();
    clear_inputs();
    drive_rd(0, 4);
    step();
    #2;
    reset = 1'b1;
    #1;
    n_tests++;
    if (pending_vec !== 16'h0 || rd_data !== '0 || rd_valid !== 2'b00 || rd_pending !== 2'b00) begin
      n_fail++;
      $display("FAIL async_reset: got pend %h data %h valid %b rdpend %b expected all zero",
               pending_vec, rd_data, rd_valid, rd_pending);
    end
    clear_inputs();
    drive_wr(0, 4, 64'h55);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    clear_inputs();
    drive_rd(0, 4);
    drive_rd(1, 5);
    step();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_collision();
    test_hold();
    test_scoreboard();
    test_bypass();
    test_back_to_back();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
